mem_uart_bridge: RTL and testbench

MEM_UART_BRIDGE -- requirements
Module: mem_uart_bridge

---
 rtl/mem_uart_bridge.sv | 242 ++++++++++++++++++++++++
 tb/tb_mem_uart_bridge.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_uart_bridge.sv
// mem_uart_bridge: turns single memory load/store requests into byte frames
// for a UART transmitter and collects the ACK or read data from the receiver.
// Frame: command byte (0x57 write / 0x52 read), address MSB first, then for
// writes the data MSB first. A write waits for 0x06. A read collects DATA_W/8
// bytes MSB first. A NAK or a response timeout resends the whole frame, up to
// MAX_RETRY times; after that the request completes with mem_err set.
// Ports:
//   clk, reset (synchronous, active-low)
//   write_enable, read_enable, address, write_data : request side
//   read_data, mem_done, mem_busy, mem_err         : completion side
//   tx_data, tx_valid, tx_ready                    : byte stream to UART TX
//   rx_data, rx_valid                              : byte strobe from UART RX
module mem_uart_bridge #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned TIMEOUT   = 1000,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_enable,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_done,
  output logic              mem_busy,
  output logic              mem_err,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid
);

  localparam int unsigned ADDR_BYTES = ADDR_W / 8;
  localparam int unsigned DATA_BYTES = DATA_W / 8;
  localparam int unsigned MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int unsigned CNT_W      = $clog2(MAX_BYTES + 1);
  localparam int unsigned RETRY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned TMO_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SEND_CMD  = 3'd1;
  localparam logic [2:0] ST_SEND_ADDR = 3'd2;
  localparam logic [2:0] ST_SEND_DATA = 3'd3;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd4;
  localparam logic [2:0] ST_RECV_DATA = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h06;

  logic [2:0]        state_q, state_d;
  logic              req_write_q, req_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;

  logic xfer_c;
  logic fail_c;
  logic ok_c;
  logic tmo_hit_c;

  assign xfer_c    = tx_valid_q && tx_ready;
  assign tmo_hit_c = (tmo_q == TMO_W'(TIMEOUT - 1));

  // Next-state, counters and registered-output values
  always_comb begin
    state_d     = state_q;
    req_write_d = req_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    tmo_d       = tmo_q;
    shift_d     = shift_q;
    read_data_d = read_data_q;
    err_d       = 1'b0;
    fail_c      = 1'b0;
    ok_c        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (write_enable || read_enable) begin
          req_write_d = write_enable;
          addr_d      = address;
          wdata_d     = write_data;
          retry_d     = '0;
          cnt_d       = '0;
          state_d     = ST_SEND_CMD;
        end
      end
      ST_SEND_CMD: begin
        if (xfer_c) begin
          cnt_d   = '0;
          state_d = ST_SEND_ADDR;
        end
      end
      ST_SEND_ADDR: begin
        if (xfer_c) begin
          if (cnt_q == CNT_W'(ADDR_BYTES - 1)) begin
            cnt_d   = '0;
            tmo_d   = '0;
            shift_d = '0;
            state_d = req_write_q ? ST_SEND_DATA : ST_RECV_DATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_SEND_DATA: begin
        if (xfer_c) begin
          if (cnt_q == CNT_W'(DATA_BYTES - 1)) begin
            cnt_d   = '0;
            tmo_d   = '0;
            state_d = ST_WAIT_ACK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WAIT_ACK: begin
        if (rx_valid) begin
          tmo_d = '0;
          if (rx_data == RSP_ACK) ok_c = 1'b1;
          else                    fail_c = 1'b1;
        end else if (tmo_hit_c) begin
          fail_c = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_RECV_DATA: begin
        if (rx_valid) begin
          tmo_d   = '0;
          shift_d = DATA_W'({shift_q, rx_data});
          if (cnt_q == CNT_W'(DATA_BYTES - 1)) begin
            ok_c        = 1'b1;
            read_data_d = shift_d;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (tmo_hit_c) begin
          fail_c = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (ok_c) begin
      cnt_d   = '0;
      state_d = ST_DONE;
    end

    // Failed attempt: resend the whole frame while retries remain
    if (fail_c) begin
      cnt_d   = '0;
      shift_d = '0;
      if (retry_q < RETRY_W'(MAX_RETRY)) begin
        retry_d = retry_q + RETRY_W'(1);
        state_d = ST_SEND_CMD;
      end else begin
        err_d   = 1'b1;
        state_d = ST_DONE;
      end
    end

    // Outputs follow the state being entered so they line up with it
    tx_valid_d = (state_d == ST_SEND_CMD) || (state_d == ST_SEND_ADDR) ||
                 (state_d == ST_SEND_DATA);
    busy_d     = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE);

    case (state_d)
      ST_SEND_CMD:  tx_data_d = req_write_d ? CMD_WRITE : CMD_READ;
      ST_SEND_ADDR: tx_data_d = 8'(addr_d >> (8 * (ADDR_BYTES - 1 - 32'(cnt_d))));
      ST_SEND_DATA: tx_data_d = 8'(wdata_d >> (8 * (DATA_BYTES - 1 - 32'(cnt_d))));
      default:      tx_data_d = 8'h00;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      req_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      retry_q     <= '0;
      tmo_q       <= '0;
      shift_q     <= '0;
      read_data_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_write_q <= req_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      tmo_q       <= tmo_d;
      shift_q     <= shift_d;
      read_data_q <= read_data_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
    end
  end

  assign read_data = read_data_q;
  assign mem_done  = done_q;
  assign mem_busy  = busy_q;
  assign mem_err   = err_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;

endmodule

// File: tb/tb_mem_uart_bridge.sv
// Bench for mem_uart_bridge: table of single-attempt transactions plus
// hand-written sequences for timeout/retry, NAK-then-ACK and mid-frame reset.
module tb_mem_uart_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        write_enable = 1'b0;
  logic        read_enable = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        mem_done, mem_busy, mem_err;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;

  int checks = 0;
  int failures = 0;
  logic bp_mode = 1'b0;
  logic [7:0] txq[$];

  mem_uart_bridge #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(16), .MAX_RETRY(2)) dut (
    .clk(clk), .reset(reset),
    .write_enable(write_enable), .read_enable(read_enable),
    .address(address), .write_data(write_data),
    .read_data(read_data), .mem_done(mem_done), .mem_busy(mem_busy), .mem_err(mem_err),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Record transfers (committed at the following rising edge) and check stall stability
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = '0;
  always @(negedge clk) begin
    if (stall_prev && reset) begin
      chk("stall_valid", tx_valid, 1'b1);
      chk("stall_data", tx_data, stall_data);
    end
    if (tx_valid && tx_ready && reset) txq.push_back(tx_data);
    stall_prev = tx_valid && !tx_ready && reset;
    stall_data = tx_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    tx_ready = bp_mode ? ~tx_ready : 1'b1;
  endtask

  task automatic issue(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    write_enable = we;
    read_enable  = re;
    address      = a;
    write_data   = d;
    tick();
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask

  task automatic wait_bytes(input string name, input int n, input int bound);
    int k = 0;
    while (txq.size() < n && k < bound) begin
      tick();
      k++;
    end
    chk(name, 64'(txq.size() >= n), 64'd1);
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic check_frame(input string name, input logic [71:0] f, input int base, input int len);
    logic [7:0] exp_b;
    for (int i = 0; i < len; i++) begin
      exp_b = f[71 - 8*i -: 8];
      if (base + i < txq.size())
        chk($sformatf("%s_byte%0d", name, i), txq[base + i], exp_b);
      else
        chk($sformatf("%s_byte%0d_missing", name, i), 64'd0, 64'd1);
    end
  endtask

  task automatic wait_done(input string name, input int bound, output int n);
    n = 0;
    while (!mem_done && n < bound) begin
      tick();
      n++;
    end
    chk(name, mem_done, 1'b1);
  endtask

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] resp;   // ack byte in [7:0] for writes, returned word for reads
    logic        bp;
    logic [71:0] frame;  // expected bytes, left aligned
    int          len;
    logic [31:0] rdata;  // read_data expected in the done cycle
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0006, 1'b0,
                72'h57_0000_0010_DEAD_BEEF, 9, 32'h0000_0000};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0004, 32'h0000_0000, 32'h1234_5678, 1'b0,
                72'h52_0000_0004_0000_0000, 5, 32'h1234_5678};
    vecs[2] = '{1'b1, 1'b1, 32'hA0B0_C0D0, 32'h0102_0304, 32'h0000_0006, 1'b1,
                72'h57_A0B0_C0D0_0102_0304, 9, 32'h1234_5678};
    vecs[3] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h5555_5555, 32'h89AB_CDEF, 1'b1,
                72'h52_FFFF_FFFF_0000_0000, 5, 32'h89AB_CDEF};

    // Reset state
    reset = 1'b0;
    tick(); tick(); tick();
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", mem_busy, 1'b0);
    chk("rst_done", mem_done, 1'b0);
    chk("rst_err", mem_err, 1'b0);
    chk("rst_read_data", read_data, 32'h0);
    reset = 1'b1;
    tick();

    // Table-driven single-attempt transactions
    for (int v = 0; v < 4; v++) begin
      txq.delete();
      bp_mode = vecs[v].bp;
      issue(vecs[v].we, vecs[v].re, vecs[v].addr, vecs[v].wdata);
      chk($sformatf("v%0d_busy", v), mem_busy, 1'b1);
      chk($sformatf("v%0d_first_valid", v), tx_valid, 1'b1);
      wait_bytes($sformatf("v%0d_frame_sent", v), vecs[v].len, 200);
      bp_mode  = 1'b0;
      tx_ready = 1'b1;
      if (vecs[v].we) begin
        send_rx(vecs[v].resp[7:0]);
      end else begin
        for (int b = 0; b < 4; b++) begin
          send_rx(vecs[v].resp[31 - 8*b -: 8]);
          if (b < 3) tick();
        end
      end
      chk($sformatf("v%0d_done", v), mem_done, 1'b1);
      chk($sformatf("v%0d_err", v), mem_err, 1'b0);
      chk($sformatf("v%0d_busy_in_done", v), mem_busy, 1'b0);
      chk($sformatf("v%0d_read_data", v), read_data, vecs[v].rdata);
      chk($sformatf("v%0d_frame_len", v), txq.size(), vecs[v].len);
      check_frame($sformatf("v%0d", v), vecs[v].frame, 0, vecs[v].len);
      tick();
      chk($sformatf("v%0d_done_pulse", v), mem_done, 1'b0);
    end

    // Timeout: no response, three identical frames, then error completion.
    // read_enable held on throughout to show requests are ignored while busy.
    txq.delete();
    write_enable = 1'b1;
    read_enable  = 1'b1;
    address      = 32'h0000_0100;
    write_data   = 32'h0BAD_F00D;
    tick();
    write_enable = 1'b0;
    address      = 32'hFFFF_FFFF;
    wait_bytes("tmo_frames_sent", 27, 300);
    read_enable  = 1'b0;
    wait_done("tmo_done", 60, n);
    chk("tmo_latency_ok", 64'(n <= 48), 64'd1);
    chk("tmo_err", mem_err, 1'b1);
    chk("tmo_frame_count", txq.size(), 27);
    for (int f = 0; f < 3; f++)
      check_frame($sformatf("tmo_f%0d", f), 72'h57_0000_0100_0BAD_F00D, 9*f, 9);
    chk("tmo_read_data_held", read_data, 32'h89AB_CDEF);
    tick();
    chk("tmo_done_pulse", mem_done, 1'b0);
    chk("tmo_err_cleared", mem_err, 1'b0);

    // NAK then ACK: exactly two frames, success
    txq.delete();
    issue(1'b1, 1'b0, 32'h0000_0020, 32'h1122_3344);
    wait_bytes("nak_frame1", 9, 100);
    send_rx(8'h15);
    chk("nak_no_done", mem_done, 1'b0);
    chk("nak_still_busy", mem_busy, 1'b1);
    wait_bytes("nak_frame2", 18, 100);
    send_rx(8'h06);
    chk("nak_done", mem_done, 1'b1);
    chk("nak_err", mem_err, 1'b0);
    chk("nak_frame_count", txq.size(), 18);
    check_frame("nak_f0", 72'h57_0000_0020_1122_3344, 0, 9);
    check_frame("nak_f1", 72'h57_0000_0020_1122_3344, 9, 9);
    tick();

    // Reset during the second address byte of a read, then a clean write
    txq.delete();
    issue(1'b0, 1'b1, 32'h1122_3344, 32'h0);
    wait_bytes("rstmid_two_bytes", 2, 50);
    chk("rstmid_second_addr_byte", tx_data, 8'h22);
    reset = 1'b0;
    tick();
    chk("rstmid_tx_valid", tx_valid, 1'b0);
    chk("rstmid_busy", mem_busy, 1'b0);
    chk("rstmid_tx_data", tx_data, 8'h00);
    chk("rstmid_read_data", read_data, 32'h0);
    reset = 1'b1;
    tick();
    chk("rstmid_idle_busy", mem_busy, 1'b0);
    txq.delete();
    issue(1'b1, 1'b0, 32'h0000_0030, 32'hCAFE_F00D);
    wait_bytes("post_rst_frame", 9, 100);
    check_frame("post_rst", 72'h57_0000_0030_CAFE_F00D, 0, 9);
    send_rx(8'h06);
    chk("post_rst_done", mem_done, 1'b1);
    chk("post_rst_err", mem_err, 1'b0);
    chk("post_rst_frame_count", txq.size(), 9);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
